// File: rtl/aes_stream_if.sv
// Streaming front-end for the AES core: packs 32-bit words into DATA_IN writes and
// unpacks DATA_OUT blocks into 32-bit words. AES_STREAM_BYTESWAP_EN byte-reverses words on both paths.
module aes_stream_if #(
  parameter int unsigned HoldoffCycles = 2,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_data_o,
  input  logic                flush_i,
  output logic [127:0]        data_in_o,
  output logic [3:0]          data_in_qe_o,
  input  logic                input_ready_i,
  input  logic [127:0]        data_out_i,
  output logic [3:0]          data_out_re_o,
  input  logic                output_valid_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] blocks_done_o
);
  localparam logic [2:0] HoldLast = 3'(HoldoffCycles - 1);

  typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_HOLD} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_EMIT, R_HOLD} r_state_e;

  function automatic logic [31:0] word_fmt(input logic [31:0] w);
`ifdef AES_STREAM_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // ---------------- packer / write path ----------------
  w_state_e     w_state_reg, w_state_next;
  logic [2:0]   wcnt_reg, wcnt_next;
  logic [2:0]   w_hold_reg, w_hold_next;
  logic [31:0]  wbuf_reg [4];
  logic [127:0] wbuf_flat;
  logic [127:0] data_in_reg;
  logic         in_accept, flush_clr, w_issue;

  assign in_ready_o = (wcnt_reg < 3'd4) & ~flush_i;
  assign in_accept  = in_valid_i & in_ready_o;
  // A full buffer is already committed to the core, so flush only drops partial blocks.
  assign flush_clr  = flush_i & (w_state_reg == W_COLLECT) & (wcnt_reg != 3'd4);
  assign w_issue    = (w_state_reg == W_ISSUE) & input_ready_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wflat
      assign wbuf_flat[32*gi +: 32] = wbuf_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) wbuf_reg[i] <= '0;
      wcnt_reg    <= 3'd0;
      w_hold_reg  <= 3'd0;
      w_state_reg <= W_COLLECT;
      data_in_reg <= '0;
    end else begin
      if (in_accept) wbuf_reg[wcnt_reg[1:0]] <= word_fmt(in_data_i);
      if (w_issue)   data_in_reg <= wbuf_flat;
      wcnt_reg    <= wcnt_next;
      w_hold_reg  <= w_hold_next;
      w_state_reg <= w_state_next;
    end
  end

  always_comb begin
    wcnt_next = wcnt_reg;
    if (w_issue || flush_clr) wcnt_next = 3'd0;
    else if (in_accept)       wcnt_next = wcnt_reg + 3'd1;
  end

  always_comb begin
    w_state_next = w_state_reg;
    w_hold_next  = 3'd0;
    case (w_state_reg)
      W_COLLECT: if (wcnt_next == 3'd4) w_state_next = W_ISSUE;
      W_ISSUE:   if (input_ready_i) w_state_next = W_HOLD;
      W_HOLD: begin
        w_hold_next = w_hold_reg + 3'd1;
        if (w_hold_reg == HoldLast) w_state_next = W_COLLECT;
      end
      default:   w_state_next = W_COLLECT;
    endcase
  end

  always_comb begin
    data_in_qe_o = {4{w_issue}};
    data_in_o    = w_issue ? wbuf_flat : data_in_reg;
  end

  // ---------------- unpacker / read path ----------------
  r_state_e              r_state_reg, r_state_next;
  logic [1:0]            rcnt_reg, rcnt_next;
  logic [2:0]            r_hold_reg, r_hold_next;
  logic [31:0]           obuf_reg [4];
  logic [31:0]           dout_word [4];
  logic [CntWidth-1:0]   blocks_done_reg, blocks_done_next;
  logic                  out_fire;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dout
      assign dout_word[gi] = data_out_i[32*gi +: 32];
    end
  endgenerate

  assign out_fire = (r_state_reg == R_EMIT) & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) obuf_reg[i] <= '0;
      rcnt_reg        <= 2'd0;
      r_hold_reg      <= 3'd0;
      r_state_reg     <= R_IDLE;
      blocks_done_reg <= '0;
    end else begin
      if (r_state_reg == R_READ) obuf_reg <= dout_word;
      rcnt_reg        <= rcnt_next;
      r_hold_reg      <= r_hold_next;
      r_state_reg     <= r_state_next;
      blocks_done_reg <= blocks_done_next;
    end
  end

  always_comb begin
    r_state_next     = r_state_reg;
    r_hold_next      = 3'd0;
    rcnt_next        = rcnt_reg;
    blocks_done_next = blocks_done_reg;
    case (r_state_reg)
      R_IDLE: if (output_valid_i) r_state_next = R_READ;
      R_READ: r_state_next = R_EMIT;
      R_EMIT: begin
        if (out_fire) begin
          rcnt_next = rcnt_reg + 2'd1;
          if (rcnt_reg == 2'd3) begin
            blocks_done_next = blocks_done_reg + {{(CntWidth-1){1'b0}}, 1'b1};
            r_state_next     = R_HOLD;
          end
        end
      end
      R_HOLD: begin
        r_hold_next = r_hold_reg + 3'd1;
        if (r_hold_reg == HoldLast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    out_valid_o   = (r_state_reg == R_EMIT);
    data_out_re_o = {4{r_state_reg == R_READ}};
    out_data_o    = word_fmt(obuf_reg[rcnt_reg]);
  end

  assign blocks_done_o = blocks_done_reg;
  assign busy_o = (wcnt_reg != 3'd0) | (w_state_reg != W_COLLECT) | (r_state_reg != R_IDLE);

endmodule

// File: tb/tb_aes_stream_if.sv
// Scoreboard bench for aes_stream_if: expected DATA_IN blocks and output words are queued
// as stimulus is driven and compared by a negedge monitor.
module tb_aes_stream_if;
  localparam int HOLD = 2;
  localparam int CW   = 16;

  logic          clk, rst_ni;
  logic          in_valid_i, in_ready_o;
  logic [31:0]   in_data_i;
  logic          out_valid_o, out_ready_i;
  logic [31:0]   out_data_o;
  logic          flush_i;
  logic [127:0]  data_in_o;
  logic [3:0]    data_in_qe_o;
  logic          input_ready_i;
  logic [127:0]  data_out_i;
  logic [3:0]    data_out_re_o;
  logic          output_valid_i;
  logic          busy_o;
  logic [CW-1:0] blocks_done_o;

  logic [127:0] exp_blk_q [$];
  logic [31:0]  exp_out_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int qe_cnt   = 0;
  int re_cnt   = 0;
  logic        stall_pending = 1'b0;
  logic [31:0] stall_data    = '0;

  aes_stream_if #(.HoldoffCycles(HOLD), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .flush_i(flush_i),
    .data_in_o(data_in_o), .data_in_qe_o(data_in_qe_o), .input_ready_i(input_ready_i),
    .data_out_i(data_out_i), .data_out_re_o(data_out_re_o), .output_valid_i(output_valid_i),
    .busy_o(busy_o), .blocks_done_o(blocks_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef AES_STREAM_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] w0, w1, w2, w3);
    return {fmt(w3), fmt(w2), fmt(w1), fmt(w0)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (in_ready_o) acc = 1'b1;
      else waited++;
      tick();
    end
    in_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
    else $display("in  word %08h after %0d stall cycles", d, waited);
  endtask

  task automatic send_block(input logic [31:0] w0, w1, w2, w3);
    int w;
    exp_blk_q.push_back(blk(w0, w1, w2, w3));
    send_word(w0, w); send_word(w1, w); send_word(w2, w); send_word(w3, w);
  endtask

  task automatic push_out_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) exp_out_q.push_back(fmt(b[32*i +: 32]));
  endtask

  task automatic check_reset_outputs(input string sfx);
    check({"rst_in_ready", sfx}, in_ready_o, 1);
    check({"rst_out_valid", sfx}, out_valid_o, 0);
    check({"rst_out_data", sfx}, out_data_o, 0);
    check({"rst_data_in", sfx}, data_in_o, 0);
    check({"rst_qe", sfx}, data_in_qe_o, 0);
    check({"rst_re", sfx}, data_out_re_o, 0);
    check({"rst_busy", sfx}, busy_o, 0);
    check({"rst_blocks", sfx}, blocks_done_o, 0);
  endtask

  // Monitor: pops the scoreboard on every strobe / handshake and checks stall stability.
  always @(negedge clk) begin
    if (data_in_qe_o != 4'h0) begin
      qe_cnt++;
      if (exp_blk_q.size() == 0) check("qe_unexpected", data_in_qe_o, 0);
      else begin
        logic [127:0] e;
        e = exp_blk_q.pop_front();
        check("qe_strobe", data_in_qe_o, 4'hf);
        check("data_in", data_in_o, e);
        $display("write block %032h", data_in_o);
      end
    end
    if (data_out_re_o != 4'h0) begin
      re_cnt++;
      check("re_strobe", data_out_re_o, 4'hf);
      $display("read  block %032h", data_out_i);
    end
    if (out_valid_o) begin
      if (stall_pending) check("out_stable", out_data_o, stall_data);
      if (out_ready_i) begin
        stall_pending = 1'b0;
        if (exp_out_q.size() == 0) check("out_unexpected", out_valid_o, 0);
        else begin
          logic [31:0] e;
          e = exp_out_q.pop_front();
          check("out_word", out_data_o, e);
          $display("out word %08h", out_data_o);
        end
      end else begin
        stall_pending = 1'b1;
        stall_data    = out_data_o;
      end
    end else stall_pending = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, n, qe0, rdy_hi, seen_done, re_gap;
    logic [CW-1:0] bd0;
    logic [127:0] b;
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    flush_i = 1'b0; input_ready_i = 1'b0; data_out_i = '0; output_valid_i = 1'b0;
    tick(); tick();
    check_reset_outputs("");
    rst_ni = 1'b1;
    tick();

    // Basic pack with core ready: qe one cycle after the 4th accept.
    input_ready_i = 1'b1;
    send_block(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    check("qe_latency", data_in_qe_o, 4'hf);
    repeat (4) tick();

    // Core not ready: packer fills and stalls, no strobe.
    input_ready_i = 1'b0;
    qe0 = qe_cnt;
    send_block(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    rdy_hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (in_ready_o) rdy_hi++;
    end
    check("stall_ready", rdy_hi, 0);
    check("stall_no_qe", qe_cnt, qe0);
    input_ready_i = 1'b1;
    #1;
    check("issue_on_ready", data_in_qe_o, 4'hf);
    tick();
    exp_blk_q.push_back(blk(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888));
    send_word(32'h55555555, w);
    check("hold_accept", w, 0);
    send_word(32'h66666666, w); send_word(32'h77777777, w); send_word(32'h88888888, w);
    repeat (6) tick();

    // Flush of a partial block.
    send_word(32'hDEAD0001, w); send_word(32'hDEAD0002, w);
    check("busy_partial", busy_o, 1);
    in_valid_i = 1'b1; in_data_i = 32'hBADBAD00; flush_i = 1'b1;
    #1;
    check("flush_ready", in_ready_o, 0);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_wcnt", busy_o, 0);
    send_block(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    repeat (6) tick();

    // Unpack one block with consumer always ready.
    out_ready_i = 1'b1;
    b = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    data_out_i = b;
    push_out_block(b);
    output_valid_i = 1'b1;
    #1;
    check("re_idle", data_out_re_o, 0);
    tick();
    output_valid_i = 1'b0;
    check("re_latency", data_out_re_o, 4'hf);
    tick();
    check("emit_latency", out_valid_o, 1);
    n = 0;
    while (blocks_done_o != 1 && n < 40) begin tick(); n++; end
    check("blocks_done_1", blocks_done_o, 1);

    // Toggling consumer, output_valid_i held high: second read must wait out the holdoff.
    b = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    data_out_i = b;
    push_out_block(b);
    push_out_block(b);
    bd0 = blocks_done_o;
    output_valid_i = 1'b1;
    seen_done = -1; re_gap = -1; n = 0;
    while (blocks_done_o != bd0 + 2 && n < 200) begin
      tick(); n++;
      out_ready_i = ~out_ready_i;
      if (seen_done < 0 && blocks_done_o == bd0 + 1) seen_done = n;
      if (seen_done >= 0 && re_gap < 0 && data_out_re_o != 4'h0) begin
        re_gap = n - seen_done;
        output_valid_i = 1'b0;
      end
    end
    output_valid_i = 1'b0;
    check("holdoff_gap", re_gap, HOLD + 1);
    check("blocks_done_3", blocks_done_o, 3);
    check("re_count", re_cnt, 3);
    out_ready_i = 1'b0;
    repeat (6) tick();

    // Reset mid-collect (wcnt=3) and mid-emit (rcnt=2).
    send_word(32'h01010101, w); send_word(32'h02020202, w); send_word(32'h03030303, w);
    b = 128'h44444444_33333333_22222222_11111111;
    data_out_i = b;
    exp_out_q.push_back(fmt(32'h11111111));
    exp_out_q.push_back(fmt(32'h22222222));
    output_valid_i = 1'b1;
    tick();
    output_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 20) begin tick(); n++; end
    check("emit_start", out_valid_o, 1);
    out_ready_i = 1'b1;
    tick(); tick();
    out_ready_i = 1'b0;
    check("busy_pre_reset", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("_async");
    tick();
    check_reset_outputs("_held");
    rst_ni = 1'b1;
    tick(); tick();

    // Recovery: fresh block after reset.
    input_ready_i = 1'b1;
    send_block(32'h00112233, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0);
    check("qe_latency_post_rst", data_in_qe_o, 4'hf);
    repeat (6) tick();

    check("blk_queue_empty", exp_blk_q.size(), 0);
    check("out_queue_empty", exp_out_q.size(), 0);
    check("qe_total", qe_cnt, 5);
    check("re_total", re_cnt, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_stream_if.md
Name: aes_stream_if

Overview:
- Streaming front-end for the AES core.
- Packs a 32-bit valid/ready plaintext/ciphertext word stream into 128-bit blocks and writes them into the core's DATA_IN registers (data + qe strobes).
- Reads completed DATA_OUT blocks (data + re strobes) and unpacks them into a 32-bit valid/ready output stream.
- Sits directly upstream/downstream of the core's data registers, beside the register file; core CTRL/KEY/IV programming is out of scope.

Parameters:
- HoldoffCycles, 2, cycles after each DATA_IN write / DATA_OUT read during which input_ready_i / output_valid_i are ignored (covers core status update latency); legal 1..7.
- CntWidth, 16, width of the completed-block counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when in_valid_i & in_ready_o
- in_data_i  in  32  input word; first word of a block = word 0 (bits 31:0 of block)
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  output consumer ready
- out_data_o  out  32  output word, word 0 first
- flush_i  in  1  discard partially collected input block
- data_in_o  out  128  block to core DATA_IN0..3 (word i at [32i+:32])
- data_in_qe_o  out  4  per-word write strobes to core
- input_ready_i  in  1  core STATUS.input_ready
- data_out_i  in  128  core DATA_OUT0..3
- data_out_re_o  out  4  per-word read strobes to core
- output_valid_i  in  1  core STATUS.output_valid
- busy_o  out  1  any word held in packer/unpacker or holdoff active
- blocks_done_o  out  CntWidth  blocks fully emitted on output stream, wraps to 0

Behaviour:
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, data_in_o=0, data_in_qe_o=0, data_out_re_o=0, busy_o=0, blocks_done_o=0. All buffers, counters and holdoff timers cleared.
- Packer: 4x32 buffer, word count wcnt 0..4.
  - in_ready_o = (wcnt<4) & !flush_i.
  - Accepted word stored at index wcnt; wcnt increments.
- Write FSM states: W_COLLECT, W_ISSUE, W_HOLD.
  - W_COLLECT -> W_ISSUE when wcnt==4.
  - W_ISSUE: waits for input_ready_i=1. In the first such cycle, data_in_o=buffer and data_in_qe_o=4'b1111 for exactly one cycle; wcnt cleared the same edge; -> W_HOLD.
  - W_HOLD: counts HoldoffCycles, then -> W_COLLECT. The packer still accepts new words during W_HOLD.
  - data_in_o holds the last written block between writes; data_in_qe_o=0 except in the issue cycle.
- Flush:
  - flush_i in W_COLLECT: wcnt cleared next edge; any same-cycle input word is not accepted.
  - flush_i in W_ISSUE/W_HOLD: ignored; a complete block is never discarded.
- Unpacker FSM states: R_IDLE, R_READ, R_EMIT, R_HOLD.
  - R_IDLE -> R_READ when output_valid_i=1.
  - R_READ (one cycle): capture data_out_i, data_out_re_o=4'b1111 -> R_EMIT.
  - R_EMIT: out_valid_o=1, out_data_o=word rcnt. Each handshake increments rcnt. After word 3 is taken, blocks_done_o increments (modulo 2^CntWidth) -> R_HOLD.
  - R_HOLD: counts HoldoffCycles -> R_IDLE.
  - out_data_o/out_valid_o stable while out_valid_o & !out_ready_i.
- Latency:
  - Last input word accepted at edge N -> qe pulse in cycle N+1 if input_ready_i=1.
  - output_valid_i high in cycle M while R_IDLE -> re pulse in cycle M+1 -> first out_valid_o in cycle M+2.
- Write and read paths are independent and may strobe in the same cycle.
- Reset mid-operation clears everything immediately; partial blocks are lost; no strobe is emitted after reset asserts.

Optional Feature:
- AES_STREAM_BYTESWAP_EN
  - Defined: each 32-bit word is byte-reversed on both paths. On entry to the packer, bytes [7:0] and [31:24] are swapped and bytes [15:8] and [23:16] are swapped. The same reversal is applied to each word on out_data_o.
  - Undefined: words pass unchanged.

Test Plan:
- Reset, then words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with input_ready_i=1 -> one cycle with data_in_qe_o=4'b1111 and data_in_o=0xCCDDEEFF_8899AABB_44556677_00112233, one cycle after the 4th accept.
- Four words with input_ready_i=0 for 10 cycles -> in_ready_o=0 and no qe. Then raise input_ready_i -> qe next cycle. A 5th word offered during W_HOLD is accepted.
- Two words, then flush_i=1 for one cycle with in_valid_i=1 -> that word not accepted, wcnt=0. Four more words -> block holds only the post-flush words.
- output_valid_i=1 with data_out_i=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> re=4'b1111 for one cycle. Outputs 0x70B4C55A, 0xD8CDB780, 0x6A7B0430, 0x69C4E0D8; blocks_done_o=1.
- out_ready_i toggled 1/0 every cycle -> out_data_o stable while stalled; all 4 words in order; output_valid_i ignored until emit + HoldoffCycles complete.
- Assert rst_ni low mid-emit (rcnt=2) and mid-collect (wcnt=3) -> next cycle all outputs at reset values, blocks_done_o=0. With AES_STREAM_BYTESWAP_EN defined, input 0x00112233 -> data_in_o word 0 = 0x33221100.
